// File: rtl/dot_product_ctrl_if.sv
// dot_product_ctrl_if: start/stream/result handshakes plus the external multiplier link.
// Carries acc_ovf only when DOT_PRODUCT_SAT_EN is defined.
interface dot_product_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16
);
    logic                    start;
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   inData_A;
    logic [DATA_WIDTH-1:0]   inData_B;
    logic [DATA_WIDTH-1:0]   mul_A;
    logic [DATA_WIDTH-1:0]   mul_B;
    logic [2*DATA_WIDTH-1:0] mul_C;
    logic                    out_valid;
    logic                    out_ready;
    logic [ACC_WIDTH-1:0]    outData;
    logic                    busy;
`ifdef DOT_PRODUCT_SAT_EN
    logic                    acc_ovf;
`endif

    modport slave (
        input  start, in_valid, inData_A, inData_B, mul_C, out_ready,
        output in_ready, mul_A, mul_B, out_valid, outData, busy
`ifdef DOT_PRODUCT_SAT_EN
        , output acc_ovf
`endif
    );

    modport master (
        output start, in_valid, inData_A, inData_B, mul_C, out_ready,
        input  in_ready, mul_A, mul_B, out_valid, outData, busy
`ifdef DOT_PRODUCT_SAT_EN
        , input acc_ovf
`endif
    );
endinterface

// File: rtl/dot_product_ctrl.sv
// dot_product_ctrl: streams VEC_LEN pairs through a shared external multiplier and accumulates.
// DOT_PRODUCT_SAT_EN selects a saturating accumulator with a sticky acc_ovf flag.
module dot_product_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 4,
    parameter int ACC_WIDTH  = 16
) (
    input logic              clk,
    input logic              rst_n,
    dot_product_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [7:0] LAST = 8'(VEC_LEN - 1);

    state_t                r_state, w_next;
    logic [7:0]            r_cnt;
    logic                  r_acc_en;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic [DATA_WIDTH-1:0] r_mul_a, r_mul_b;
    logic                  w_hs, w_start;
    logic                  w_in_ready, w_out_valid, w_busy;
    logic [ACC_WIDTH-1:0]  w_out_data;

    assign w_hs    = (r_state == RUN) && bus.in_valid;
    assign w_start = (r_state == IDLE) && bus.start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = r_state == RUN;
        w_out_valid = r_state == DONE;
        w_busy      = r_state != IDLE;
        w_out_data  = w_out_valid ? r_acc : '0;
        case (r_state)
            IDLE:    w_next = bus.start ? RUN : IDLE;
            RUN:     w_next = (w_hs && r_cnt == LAST) ? DRAIN : RUN;
            DRAIN:   w_next = DONE;
            DONE:    w_next = bus.out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

`ifdef DOT_PRODUCT_SAT_EN
    localparam int AW1 = ACC_WIDTH + 1;
    logic           r_ovf;
    logic [AW1-1:0] w_sum;
    assign w_sum   = {1'b0, r_acc} + AW1'(bus.mul_C);
    assign bus.acc_ovf = r_ovf;
`else
    logic [ACC_WIDTH-1:0] w_sum;
    assign w_sum = r_acc + ACC_WIDTH'(bus.mul_C);
`endif

    // The product of a handshake is ready one cycle later, so accumulation lags by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_acc_en <= 1'b0;
            r_acc    <= '0;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
`ifdef DOT_PRODUCT_SAT_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            r_acc_en <= w_hs;
            if (w_hs) begin
                r_mul_a <= bus.inData_A;
                r_mul_b <= bus.inData_B;
                r_cnt   <= r_cnt + 8'd1;
            end
            if (w_start) begin
                r_acc <= '0;
                r_cnt <= '0;
`ifdef DOT_PRODUCT_SAT_EN
                r_ovf <= 1'b0;
`endif
            end else if (r_acc_en) begin
`ifdef DOT_PRODUCT_SAT_EN
                if (w_sum[ACC_WIDTH]) begin
                    r_acc <= '1;
                    r_ovf <= 1'b1;
                end else begin
                    r_acc <= w_sum[ACC_WIDTH-1:0];
                end
`else
                r_acc <= w_sum;
`endif
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.outData   = w_out_data;
    assign bus.mul_A     = r_mul_a;
    assign bus.mul_B     = r_mul_b;
endmodule

// File: doc/dot_product_ctrl.md
DOT_PRODUCT_CTRL -- requirements
Module: dot_product_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the operand width of the shared vedic multiplier.
REQ-002 SHALL have parameter VEC_LEN, default 4, giving the element pairs per dot product (2..255).
REQ-003 SHALL have parameter ACC_WIDTH, default 16, giving the accumulator and result width (>= 2*DATA_WIDTH).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, which begins a dot product when sampled high in IDLE.
REQ-007 SHALL have port in_valid, input, 1, meaning the inData_A/inData_B pair is valid.
REQ-008 SHALL have port in_ready, output, 1, meaning the block accepts a pair this cycle.
REQ-009 SHALL have ports inData_A and inData_B, input, DATA_WIDTH each, the element pair.
REQ-010 SHALL have ports mul_A and mul_B, output, DATA_WIDTH each, registered operands to the external vedicmultiplier_8bit.
REQ-011 SHALL have port mul_C, input, 2*DATA_WIDTH, the combinational product returned by the multiplier.
REQ-012 SHALL have port out_valid, output, 1, meaning outData holds a completed result.
REQ-013 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-014 SHALL have port outData, output, ACC_WIDTH, the dot-product result.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-016 SHALL implement the FSM IDLE -> RUN (start) -> DRAIN (VEC_LEN-th input handshake) -> DONE (next cycle) -> IDLE (out_valid && out_ready).
REQ-017 SHALL, on start in IDLE, clear the accumulator and the element counter to 0.
REQ-018 SHALL drive in_ready high only in RUN; an input handshake is in_valid && in_ready.
REQ-019 SHALL register the operands of each handshake into mul_A/mul_B and set a one-cycle accumulate-enable; mul_A/mul_B hold their value otherwise.
REQ-020 SHALL add zero-extended mul_C to the accumulator in the cycle after each handshake; back-to-back handshakes every cycle are supported without stalls.
REQ-021 SHALL tolerate in_valid bubbles of any length in RUN without losing or duplicating pairs.
REQ-022 SHALL assert out_valid exactly 2 cycles after the final input handshake, with outData equal to the final accumulator.
REQ-023 SHALL hold out_valid and outData stable in DONE until out_ready is high.
REQ-024 SHALL ignore start outside IDLE, in_valid outside RUN, and out_ready outside DONE.
REQ-025 SHALL treat the DONE-exit cycle as non-IDLE; a start in that cycle is ignored.
REQ-026 SHALL, without the macro of REQ-030, accumulate modulo 2^ACC_WIDTH.

Reset
REQ-027 SHALL, on rst_n low, immediately force the state to IDLE and clear the accumulator, counter, accumulate-enable, mul_A and mul_B.
REQ-028 SHALL, during reset, drive in_ready, out_valid, busy and outData to 0, regardless of clk and including mid-operation.
REQ-029 SHALL begin normal operation on the first rising clk edge after rst_n deasserts.

Configuration
REQ-030 SHALL, with DOT_PRODUCT_SAT_EN defined, clamp the accumulator at 2^ACC_WIDTH-1 on overflow and add output port acc_ovf (1 bit), set sticky until the next start or reset.
REQ-031 SHALL, without DOT_PRODUCT_SAT_EN, omit acc_ovf and wrap per REQ-026.

Verification
REQ-032 SHALL cover: start, then pairs (1,2),(3,4),(5,6),(7,8) back-to-back -> out_valid 2 cycles after the 4th handshake, outData=100.
REQ-033 SHALL cover: four pairs of (255,255) -> outData=63492 without the macro; outData=65535 and acc_ovf=1 with DOT_PRODUCT_SAT_EN.
REQ-034 SHALL cover: the pairs of REQ-032 with 3-cycle in_valid gaps and out_ready held low for 5 cycles -> outData=100, stable while out_valid is high.
REQ-035 SHALL cover: rst_n pulsed low after 2 handshakes -> outputs 0 at once, state IDLE; a fresh run of REQ-032 then gives 100.
REQ-036 SHALL cover: start pulsed in RUN and in DONE, and in_valid high in IDLE -> no state or accumulator change; in_ready stays 0 outside RUN.
